// File: rtl/miriscv_uart_pkg.sv
// Shared register map, STATUS bit layout and transmitter FSM encoding for the UART TX block.
// Build option: MIRISCV_UART_PARITY_EN adds a parity bit slot between the data bits and the stop bit.
package miriscv_uart_pkg;

  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] BAUD   = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 8;

`ifdef MIRISCV_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Single-clock FIFO with a separate level counter; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module miriscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/miriscv_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first, idle high) on the core data bus.
// Build option: MIRISCV_UART_PARITY_EN enables a parity slot and the CTRL.ODD bit.
module miriscv_uart_tx
  import miriscv_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             sel, wr_en, rd_en;
  logic [1:0]       reg_idx;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       fifo_head;
  logic             ovf_q, en_q;
  logic [15:0]      baud_div;
  logic             unused_bits;

  uart_state_t state;
  logic [15:0] cnt;
  logic [15:0] div_cur;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        tick;
`ifdef MIRISCV_UART_PARITY_EN
  logic        odd_q;
  logic        par_q;
`endif

  assign sel         = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx     = data_addr_i[3:2];
  assign wr_en       = sel && data_we_i;
  assign rd_en       = sel && !data_we_i;
  assign unused_bits = ^{data_addr_i[1:0], data_wdata_i[31:16], data_be_i[3:2]};

  assign push = wr_en && (reg_idx == TXDATA) && data_be_i[0];
  assign pop  = (state == IDLE) && en_q && !fifo_empty;
  assign tick = (cnt == div_cur);

  // Queued bytes count as busy only while they are allowed to go out.
  assign busy_o = (state != IDLE) || (en_q && !fifo_empty);

  miriscv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (data_wdata_i[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Register file: overflow set has priority over a W1C clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      baud_div <= DEFAULT_DIV;
`ifdef MIRISCV_UART_PARITY_EN
      odd_q    <= 1'b0;
`endif
    end else begin
      if (push && fifo_full && !pop)
        ovf_q <= 1'b1;
      else if (wr_en && (reg_idx == STATUS) && data_be_i[0] && data_wdata_i[ST_OVF])
        ovf_q <= 1'b0;
      if (wr_en && (reg_idx == BAUD)) begin
        if (data_be_i[0]) baud_div[7:0]  <= data_wdata_i[7:0];
        if (data_be_i[1]) baud_div[15:8] <= data_wdata_i[15:8];
      end
      if (wr_en && (reg_idx == CTRL) && data_be_i[0]) begin
        en_q  <= data_wdata_i[0];
`ifdef MIRISCV_UART_PARITY_EN
        odd_q <= data_wdata_i[1];
`endif
      end
    end
  end

  always_comb begin
    data_rdata_o = '0;
    if (rd_en) begin
      case (reg_idx)
        STATUS: begin
          data_rdata_o[ST_BUSY]        = busy_o;
          data_rdata_o[ST_FULL]        = fifo_full;
          data_rdata_o[ST_EMPTY]       = fifo_empty;
          data_rdata_o[ST_OVF]         = ovf_q;
          data_rdata_o[ST_LVL +: 8]    = 8'(fifo_level);
        end
        BAUD:  data_rdata_o[15:0] = baud_div;
        CTRL: begin
          data_rdata_o[0] = en_q;
`ifdef MIRISCV_UART_PARITY_EN
          data_rdata_o[1] = odd_q;
`endif
        end
        default: data_rdata_o = '0;
      endcase
    end
  end

  // Divisor is latched at every bit boundary so a BAUD_DIV write never stretches the current bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            shreg   <= fifo_head;
            div_cur <= baud_div;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_o    <= 1'b0;
`ifdef MIRISCV_UART_PARITY_EN
            par_q   <= ^fifo_head;
`endif
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            cnt     <= '0;
            div_cur <= baud_div;
            tx_o    <= shreg[0];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt     <= '0;
            div_cur <= baud_div;
            if (bit_cnt == 3'd7) begin
`ifdef MIRISCV_UART_PARITY_EN
              state <= PARITY;
              tx_o  <= par_q ^ odd_q;
`else
              state <= STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_o    <= shreg[1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef MIRISCV_UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            cnt     <= '0;
            div_cur <= baud_div;
            tx_o    <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            cnt   <= '0;
            tx_o  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Self-checking bench for miriscv_uart_tx: bytes written to TXDATA are queued and
// compared against frames decoded from tx_o; register reads are checked directly.
module tb_miriscv_uart_tx;

`ifdef MIRISCV_UART_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        tx_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int len_tab[NSLOT];
  int mon_slot = -1;
  int frames_done = 0;
  int last_gap = 0;
  logic busy_at_stop = 1'b0;

  always #5 clk = ~clk;

  miriscv_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = be;
    data_addr_i = addr; data_wdata_i = data;
    @(negedge clk);
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = addr;
    #1 data = data_rdata_o;
    data_req_i = 1'b0; data_be_i = 4'h0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check_vec(tag, d, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus_write(BASE, {24'h0, b}, 4'h1);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_len(input int first_len, input int split, input int second_len);
    for (int s = 0; s < NSLOT; s++) len_tab[s] = (s < split) ? first_len : second_len;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_vec("frame_done", frames_done, target);
  endtask

  task automatic wait_slot(input int slot, input int budget);
    int n = 0;
    while (mon_slot != slot && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_vec("slot_reached", mon_slot, slot);
  endtask

  // Decode one frame whose start bit was seen at the current negedge.
  task automatic take_frame(input int gap);
    logic [7:0] b;
    logic       exp_bits[NSLOT];
    int         hits;
    logic       aborted;
    last_gap = gap;
    check_vec("frame_queued", 32'(exp_q.size() > 0), 32'd1);
    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef MIRISCV_UART_PARITY_EN
    exp_bits[9] = ^b;
`endif
    exp_bits[NSLOT-1] = 1'b1;
    aborted = 1'b0;
    for (int s = 0; s < NSLOT && !aborted; s++) begin
      mon_slot = s;
      hits = 0;
      for (int c = 0; c < len_tab[s]; c++) begin
        if (c > 0 || s > 0) @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (tx_o === exp_bits[s]) hits++;
      end
      if (!aborted) check_vec($sformatf("byte%02h_slot%0d", b, s), hits, len_tab[s]);
    end
    if (!aborted) begin
      busy_at_stop = busy_o;
      frames_done++;
    end
    mon_slot = -1;
  endtask

  initial begin
    int idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) idle_cnt = 0;
      else if (tx_o) idle_cnt++;
      else begin
        take_frame(idle_cnt);
        idle_cnt = 0;
      end
    end
  end

  initial begin
    int busy_low;
    int n;
    set_len(868, NSLOT, 868);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_vec("reset_tx", tx_o, 1);
    check_vec("reset_busy", busy_o, 0);
    read_check("reset_status", BASE + 32'h4, 32'h0000_0004);
    read_check("reset_baud", BASE + 32'h8, 32'd867);
    read_check("reset_ctrl", BASE + 32'hC, 32'h0);

    // Single 0xA5 frame at DIV=3
    bus_write(BASE + 32'hC, 32'h1, 4'h1);
    bus_write(BASE + 32'h8, 32'h3, 4'h3);
    set_len(4, NSLOT, 4);
    push_byte(8'hA5);
    wait_frames(1, 200);
    check_vec("busy_during_stop", busy_at_stop, 1);
    @(negedge clk);
    check_vec("busy_after_stop", busy_o, 0);

    // Overflow with transmitter disabled
    bus_write(BASE + 32'hC, 32'h0, 4'h1);
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    read_check("status_ovf", BASE + 32'h4, 32'h0000_040A);
    bus_write(BASE + 32'h4, 32'h8, 4'h1);
    read_check("status_w1c", BASE + 32'h4, 32'h0000_0402);
    do_reset();

    // Accesses outside the register window
    bus_write(BASE + 32'h20, 32'h5A, 4'hF);
    bus_write(BASE + 32'h28, 32'h5, 4'hF);
    bus_write(BASE + 32'h2C, 32'h1, 4'hF);
    bus_write(32'h0000_0008, 32'h5, 4'hF);
    bus_write(32'h0000_000C, 32'h1, 4'hF);
    exp_q.delete();
    read_check("unmapped_hi_rd", BASE + 32'h24, 32'h0);
    read_check("unmapped_zero_rd", 32'h0000_0004, 32'h0);
    read_check("baud_untouched", BASE + 32'h8, 32'd867);
    read_check("status_untouched", BASE + 32'h4, 32'h0000_0004);
    read_check("ctrl_untouched", BASE + 32'hC, 32'h0);
    @(negedge clk);
    data_addr_i = BASE + 32'h8; data_req_i = 1'b0;
    #1 check_vec("rdata_no_req", data_rdata_o, 32'h0);

    // Back-to-back frames at DIV=0
    bus_write(BASE + 32'h8, 32'h0, 4'h3);
    bus_write(BASE + 32'hC, 32'h1, 4'h1);
    set_len(1, NSLOT, 1);
    push_byte(8'h01);
    push_byte(8'h02);
    busy_low = 0;
    n = 0;
    while (frames_done < 3 && n < 100) begin
      @(negedge clk);
      if (!busy_o) busy_low++;
      n++;
    end
    check_vec("b2b_frames", frames_done, 3);
    check_vec("b2b_gap", last_gap, 1);
    check_vec("b2b_busy_low", busy_low, 0);

    // Divisor change during data bit 3 (slot 4)
    bus_write(BASE + 32'h8, 32'h3, 4'h3);
    set_len(4, 5, 8);
    push_byte(8'hC3);
    wait_slot(4, 200);
    bus_write(BASE + 32'h8, 32'h7, 4'h1);
    wait_frames(4, 400);
    read_check("baud_new", BASE + 32'h8, 32'd7);

    // Reset in the middle of data bit 5 (slot 6)
    set_len(8, NSLOT, 8);
    push_byte(8'h5A);
    wait_slot(6, 400);
    reset = 1'b1;
    @(negedge clk);
    check_vec("midreset_tx", tx_o, 1);
    check_vec("midreset_busy", busy_o, 0);
    read_check("midreset_status", BASE + 32'h4, 32'h0000_0004);
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check_vec("no_frame_after_reset", frames_done, 4);
    check_vec("idle_tx", tx_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
